// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter that time-shares one Gray-code converter between NUM_REQ requesters.
// One request in flight at a time: accept, drive converter for one cycle, return result.
module gray_conv_arbiter #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned NUM_REQ = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [NUM_REQ-1:0]           req_valid_i,
   input  logic [NUM_REQ*WIDTH-1:0]     req_data_i,
   output logic [NUM_REQ-1:0]           req_ready_o,
   output logic [2:0]                   conv_en_o,
   output logic [WIDTH-1:0]             conv_data_o,
   input  logic [WIDTH-1:0]             conv_data_i,
   output logic                         rsp_valid_o,
   input  logic                         rsp_ready_i,
   output logic [WIDTH-1:0]             rsp_data_o,
   output logic [$clog2(NUM_REQ)-1:0]   rsp_id_o
);

   localparam int unsigned ID_W  = $clog2(NUM_REQ);
   localparam int unsigned CNT_W = ID_W + 1;
   localparam logic [2:0]  CONV_EN_CODE = 3'b100;
   localparam logic [2:0]  IDLE_EN_CODE = 3'b000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t             state_q;
   logic [ID_W-1:0]    ptr_q;
   logic [ID_W-1:0]    id_q;
   logic [2:0]         conv_en_q;
   logic [WIDTH-1:0]   conv_data_q;
   logic               rsp_valid_q;
   logic [WIDTH-1:0]   rsp_data_q;
   logic [ID_W-1:0]    rsp_id_q;

   logic [CNT_W-1:0]   scan_idx;
   logic               win_found;
   logic [ID_W-1:0]    win_idx;
   logic [WIDTH-1:0]   win_data;
   logic [ID_W-1:0]    ptr_d;

   // Round-robin scan starting at ptr_q, wrapping modulo NUM_REQ.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_idx  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         scan_idx = CNT_W'(ptr_q) + CNT_W'(i);
         if (scan_idx >= CNT_W'(NUM_REQ)) begin
            scan_idx = scan_idx - CNT_W'(NUM_REQ);
         end
         if (!win_found && req_valid_i[scan_idx[ID_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = scan_idx[ID_W-1:0];
         end
      end
   end

   always_comb begin
      win_data = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (win_idx == ID_W'(k)) begin
            win_data = req_data_i[k*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      if (win_idx == ID_W'(NUM_REQ - 1)) begin
         ptr_d = '0;
      end else begin
         ptr_d = win_idx + ID_W'(1);
      end
   end

   // Grant is only offered while idle and never on a reset cycle.
   always_comb begin
      req_ready_o = '0;
      if (!rst_i && (state_q == IDLE) && win_found) begin
         req_ready_o[win_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         id_q        <= '0;
         conv_en_q   <= IDLE_EN_CODE;
         conv_data_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_id_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (win_found) begin
                  id_q        <= win_idx;
                  ptr_q       <= ptr_d;
                  conv_en_q   <= CONV_EN_CODE;
                  conv_data_q <= win_data;
                  state_q     <= CONV;
               end
            end
            CONV: begin
               rsp_data_q  <= conv_data_i;
               rsp_id_q    <= id_q;
               rsp_valid_q <= 1'b1;
               conv_en_q   <= IDLE_EN_CODE;
               conv_data_q <= '0;
               state_q     <= RESP;
            end
            RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign conv_en_o   = conv_en_q;
   assign conv_data_o = conv_data_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = rsp_data_q;
   assign rsp_id_o    = rsp_id_q;

endmodule
